// File: rtl/wb_key_poller.sv
`default_nettype none
// ============================================================================
// Module   : wb_key_poller
// Purpose  : Wishbone classic read-only master. It polls the keypad KEY_CR and
//            KEY_DATA registers and queues each new key press in a small FIFO.
//            Define KEY_POLLER_ASCII_EN to store the full ASCII-style byte
//            instead of the low nibble.
// Revision : 1.0 - initial release
// ============================================================================
module wb_key_poller #(
    parameter logic [31:0] BASE_ADR    = 32'hF0020000,
    parameter int          POLL_CYCLES = 5000,
    parameter int          TIMEOUT     = 16,
    parameter int          FIFO_LOG2   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        key_valid,
    output logic [7:0]  key_data,
    input  logic        key_rd,
    output logic        overflow,
    output logic        bus_err,
    input  logic        clr_flags
);

    localparam int c_poll_w = $clog2(POLL_CYCLES);
    localparam int c_to_w   = $clog2(TIMEOUT);
    localparam int c_depth  = 2 ** FIFO_LOG2;
    localparam logic [c_poll_w-1:0] c_poll_last = c_poll_w'(POLL_CYCLES - 1);
    localparam logic [c_to_w-1:0]   c_to_last   = c_to_w'(TIMEOUT - 1);
    localparam logic [31:0]         c_data_adr  = BASE_ADR + 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_CR   = 2'd1,
        ST_GAP     = 2'd2,
        ST_RD_DATA = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_poll_w-1:0]   r_poll_cnt;
    logic [c_to_w-1:0]     r_to_cnt;
    logic                  r_prev_irq;

    logic [7:0]            r_mem [c_depth];
    logic [FIFO_LOG2:0]    r_wr_ptr;
    logic [FIFO_LOG2:0]    r_rd_ptr;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_push_req;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_timeout;
    logic [7:0]            w_code;
    logic [FIFO_LOG2:0]    w_wr_ptr_nxt;
    logic [FIFO_LOG2:0]    w_rd_ptr_nxt;
    logic [7:0]            w_head_nxt;
    logic                  w_unused;

    assign wb_we_o   = 1'b0;
    assign wb_sel_o  = 4'b0001;
    assign key_valid = !w_empty;
    assign w_unused  = ^wb_dat_i;

`ifdef KEY_POLLER_ASCII_EN
    assign w_code = wb_dat_i[7:0];
`else
    assign w_code = {4'h0, wb_dat_i[3:0]};
`endif

    // An ack in the expiry cycle wins over the timeout.
    assign w_timeout = ((r_state == ST_RD_CR) || (r_state == ST_RD_DATA))
                       && !wb_ack_i && (r_to_cnt == c_to_last);

    always_comb begin
        w_empty      = (r_wr_ptr == r_rd_ptr);
        w_full       = (r_wr_ptr[FIFO_LOG2] != r_rd_ptr[FIFO_LOG2]) &&
                       (r_wr_ptr[FIFO_LOG2-1:0] == r_rd_ptr[FIFO_LOG2-1:0]);
        w_push_req   = (r_state == ST_RD_DATA) && wb_ack_i;
        w_pop        = key_rd && !w_empty;
        w_push       = w_push_req && (!w_full || w_pop);
        w_drop       = w_push_req && w_full && !w_pop;
        w_wr_ptr_nxt = r_wr_ptr + {{FIFO_LOG2{1'b0}}, w_push};
        w_rd_ptr_nxt = r_rd_ptr + {{FIFO_LOG2{1'b0}}, w_pop};
        // Next head bypasses the memory when the pushed word becomes the head.
        if (w_wr_ptr_nxt == w_rd_ptr_nxt) begin
            w_head_nxt = 8'h00;
        end else if (w_push &&
                     (w_rd_ptr_nxt[FIFO_LOG2-1:0] == r_wr_ptr[FIFO_LOG2-1:0])) begin
            w_head_nxt = w_code;
        end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt[FIFO_LOG2-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_LOG2-1:0]] <= w_code;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            key_data <= 8'h00;
            overflow <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            key_data <= w_head_nxt;
            if (clr_flags) begin
                overflow <= 1'b0;
                bus_err  <= 1'b0;
            end else begin
                if (w_drop) begin
                    overflow <= 1'b1;
                end
                if (w_timeout) begin
                    bus_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_poll_cnt <= '0;
            r_to_cnt   <= '0;
            r_prev_irq <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_adr_o   <= BASE_ADR;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_poll_cnt == c_poll_last) begin
                        r_poll_cnt <= '0;
                        r_to_cnt   <= '0;
                        wb_adr_o   <= BASE_ADR;
                        wb_cyc_o   <= 1'b1;
                        wb_stb_o   <= 1'b1;
                        r_state    <= ST_RD_CR;
                    end else begin
                        r_poll_cnt <= r_poll_cnt + 1'b1;
                    end
                end
                ST_RD_CR: begin
                    if (wb_ack_i) begin
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        r_prev_irq <= wb_dat_i[0];
                        r_state    <= (wb_dat_i[0] && !r_prev_irq) ? ST_GAP : ST_IDLE;
                    end else if (w_timeout) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    r_to_cnt <= '0;
                    wb_adr_o <= c_data_adr;
                    wb_cyc_o <= 1'b1;
                    wb_stb_o <= 1'b1;
                    r_state  <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (wb_ack_i || w_timeout) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: begin
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_key_poller.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_key_poller
// Purpose  : Directed self-checking bench for wb_key_poller with a
//            registered-ack keypad slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_key_poller;

    localparam logic [31:0] c_base = 32'hF0020000;
    localparam logic [31:0] c_data = 32'hF0020004;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i = 1'b0;
    logic        key_valid;
    logic [7:0]  key_data;
    logic        key_rd, overflow, bus_err, clr_flags;

    logic        slave_en = 1'b1;
    logic        cr_val   = 1'b0;
    logic [7:0]  data_val = 8'h00;
    int          cr_done   = 0;
    int          data_done = 0;
    int          bad_adr   = 0;
    int          n_cmp     = 0;
    int          n_err     = 0;

    wb_key_poller #(
        .BASE_ADR    (c_base),
        .POLL_CYCLES (8),
        .TIMEOUT     (16),
        .FIFO_LOG2   (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_sel_o  (wb_sel_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .key_valid (key_valid),
        .key_data  (key_data),
        .key_rd    (key_rd),
        .overflow  (overflow),
        .bus_err   (bus_err),
        .clr_flags (clr_flags)
    );

    always #5 clk = ~clk;

    // Keypad slave: registered ack, never acks two cycles in a row.
    assign wb_dat_i = (wb_adr_o == c_data) ? {24'h0, data_val} : {31'h0, cr_val};
    always @(posedge clk) wb_ack_i <= slave_en && wb_cyc_o && wb_stb_o && !wb_ack_i;

    always @(posedge clk) begin
        if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
            if (wb_adr_o == c_base)      cr_done   <= cr_done + 1;
            else if (wb_adr_o == c_data) data_done <= data_done + 1;
            else                         bad_adr   <= bad_adr + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_code(input logic [7:0] d);
`ifdef KEY_POLLER_ASCII_EN
        return d;
`else
        return {4'h0, d[3:0]};
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_polls(input int n);
        int tgt = cr_done + n;
        int k   = 0;
        while (cr_done < tgt && k < 40 * n) begin
            @(posedge clk); #1;
            k++;
        end
        chk("poll_progress", 32'(cr_done >= tgt), 32'd1);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] d);
        cr_val = 1'b0;
        wait_polls(1);
        cr_val   = 1'b1;
        data_val = d;
        wait_polls(1);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] d);
        chk(tag, {24'h0, key_data}, {24'h0, exp_code(d)});
        key_rd = 1'b1;
        @(posedge clk); #1;
        key_rd = 1'b0;
    endtask

    task automatic wait_data_stb(input bit need_ack);
        int k = 0;
        @(negedge clk);
        while (!(wb_stb_o && wb_adr_o == c_data && (!need_ack || wb_ack_i)) && k < 80) begin
            @(negedge clk);
            k++;
        end
        chk("data_stb_seen", 32'(k < 80), 32'd1);
    endtask

    initial begin
        int n;
        int dd;
        reset = 1'b0; key_rd = 1'b0; clr_flags = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc",  {31'h0, wb_cyc_o}, 32'd0);
        chk("rst_stb",  {31'h0, wb_stb_o}, 32'd0);
        chk("rst_adr",  wb_adr_o, c_base);
        chk("rst_valid", {31'h0, key_valid}, 32'd0);
        chk("rst_data", {24'h0, key_data}, 32'd0);
        chk("rst_flags", {30'h0, overflow, bus_err}, 32'd0);

        // First poll starts 8 cycles after release.
        reset = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("stb_early", {31'h0, wb_stb_o}, 32'd0);
        @(posedge clk); #1;
        chk("stb_first", {30'h0, wb_cyc_o, wb_stb_o}, 32'd3);
        chk("adr_first", wb_adr_o, c_base);
        chk("sel_we",    {27'h0, wb_sel_o, wb_we_o}, {27'h0, 4'b0001, 1'b0});

        // Key visible during this very poll.
        cr_val = 1'b1; data_val = 8'h37;
        wait_polls(1);
        chk("first_data_reads", data_done, 32'd1);
        chk("first_valid", {31'h0, key_valid}, 32'd1);
        chk("first_code", {24'h0, key_data}, {24'h0, exp_code(8'h37)});

        wait_polls(5);
        chk("held_no_push", data_done, 32'd1);

        press(8'h32);
        chk("second_data_reads", data_done, 32'd2);
        pop_chk("pop_a", 8'h37);
        pop_chk("pop_b", 8'h32);
        chk("drained", {31'h0, key_valid}, 32'd0);

        // Overflow: five presses into a four-deep FIFO.
        press(8'h31); press(8'h32); press(8'h33); press(8'h34);
        chk("ovf_not_yet", {31'h0, overflow}, 32'd0);
        press(8'h35);
        chk("ovf_set", {31'h0, overflow}, 32'd1);
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        chk("ovf_clr", {31'h0, overflow}, 32'd0);
        pop_chk("ovf_pop1", 8'h31);
        pop_chk("ovf_pop2", 8'h32);
        pop_chk("ovf_pop3", 8'h33);
        pop_chk("ovf_pop4", 8'h34);
        chk("ovf_empty", {31'h0, key_valid}, 32'd0);

        // Full FIFO, new press with a pop in the push cycle.
        press(8'h36); press(8'h37); press(8'h38); press(8'h39);
        cr_val = 1'b0;
        wait_polls(1);
        cr_val = 1'b1; data_val = 8'h3A;
        wait_data_stb(1'b1);
        key_rd = 1'b1;
        @(posedge clk); #1;
        key_rd = 1'b0;
        chk("full_pp_ovf", {31'h0, overflow}, 32'd0);
        pop_chk("full_pop1", 8'h37);
        pop_chk("full_pop2", 8'h38);
        pop_chk("full_pop3", 8'h39);
        pop_chk("full_pop4", 8'h3A);
        chk("full_empty", {31'h0, key_valid}, 32'd0);

        // Silent slave: stb stays up exactly TIMEOUT cycles.
        slave_en = 1'b0;
        dd = data_done;
        n = 0;
        while (!wb_stb_o && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        n = 0;
        while (wb_stb_o && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        chk("to_stb_len", n, 32'd16);
        chk("to_cyc_low", {31'h0, wb_cyc_o}, 32'd0);
        chk("to_bus_err", {31'h0, bus_err}, 32'd1);
        slave_en = 1'b1;
        wait_polls(1);
        chk("to_no_push", {31'h0, key_valid}, 32'd0);
        chk("to_no_data", data_done, dd);
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        chk("berr_clr", {31'h0, bus_err}, 32'd0);

        // Reset while the data read is outstanding.
        cr_val = 1'b0;
        wait_polls(1);
        cr_val = 1'b1; data_val = 8'h35;
        wait_data_stb(1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_bus", {30'h0, wb_cyc_o, wb_stb_o}, 32'd0);
        chk("rstmid_valid", {31'h0, key_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rstmid_after", {31'h0, key_valid}, 32'd0);
        chk("bad_adr", bad_adr, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
